// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, LSU size codes, FSM encodings and the
//               alignment helper used by the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_reg_bus = 64;

    localparam logic [2:0] c_lsu_b  = 3'b000;
    localparam logic [2:0] c_lsu_h  = 3'b001;
    localparam logic [2:0] c_lsu_w  = 3'b010;
    localparam logic [2:0] c_lsu_d  = 3'b011;
    localparam logic [2:0] c_lsu_bu = 3'b100;
    localparam logic [2:0] c_lsu_hu = 3'b101;
    localparam logic [2:0] c_lsu_wu = 3'b110;

    typedef logic [1:0] state_t;
    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_req  = 2'd1;
    localparam state_t c_st_wait = 2'd2;

    // Natural alignment: size code in funct3[1:0] selects how many low bits must be zero.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
        logic r;
        r = 1'b0;
        case (funct3[1:0])
            2'd1:    r = addr_lo[0];
            2'd2:    r = |addr_lo[1:0];
            2'd3:    r = |addr_lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_align
// Description : Combinational byte-lane steering: store data/mask placement
//               and load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]           i_funct3,
    input  logic [2:0]           i_addr_lo,
    input  logic [c_reg_bus-1:0] i_wdata,
    input  logic [c_reg_bus-1:0] i_rdata,
    output logic [c_reg_bus-1:0] o_wdata,
    output logic [7:0]           o_wmask,
    output logic [c_reg_bus-1:0] o_rdata
);

    logic [7:0]           w_base_mask;
    logic [c_reg_bus-1:0] w_shifted;

    always_comb begin
        w_base_mask = 8'h00;
        case (i_funct3[1:0])
            2'd0:    w_base_mask = 8'h01;
            2'd1:    w_base_mask = 8'h03;
            2'd2:    w_base_mask = 8'h0F;
            default: w_base_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off the top of the doubleword.
    assign o_wmask   = w_base_mask << i_addr_lo;
    assign o_wdata   = i_wdata << {i_addr_lo, 3'b000};
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (i_funct3)
            c_lsu_b:  o_rdata = {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_lsu_h:  o_rdata = {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_lsu_w:  o_rdata = {{32{w_shifted[31]}}, w_shifted[31:0]};
            c_lsu_bu: o_rdata = {56'd0, w_shifted[7:0]};
            c_lsu_hu: o_rdata = {48'd0, w_shifted[15:0]};
            c_lsu_wu: o_rdata = {32'd0, w_shifted[31:0]};
            default:  o_rdata = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage between EX and WB with a
//               req/gnt/rvalid data-memory port. Optional misaligned-access
//               trap enabled by defining MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mem_rd,
    input  logic                 in_mem_wr,
    input  logic [2:0]           in_funct3,
    input  logic [c_reg_bus-1:0] in_addr,
    input  logic [c_reg_bus-1:0] in_wdata,
    input  logic                 in_pc_to_reg,
    input  logic                 in_exe_to_reg,
    input  logic                 in_csr_to_reg,
    input  logic [c_reg_bus-1:0] in_exe_data,
    input  logic [c_reg_bus-1:0] in_pc_data,
    input  logic [c_reg_bus-1:0] in_csr_data,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_wen,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [c_reg_bus-1:0] dmem_addr,
    output logic [c_reg_bus-1:0] dmem_wdata,
    output logic [7:0]           dmem_wmask,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [c_reg_bus-1:0] dmem_rdata,
    output logic                 out_valid,
    output logic                 out_mem_to_reg,
    output logic                 out_pc_to_reg,
    output logic                 out_exe_to_reg,
    output logic                 out_csr_to_reg,
    output logic [c_reg_bus-1:0] out_mem_data,
    output logic [c_reg_bus-1:0] out_exe_data,
    output logic [c_reg_bus-1:0] out_pc_data,
    output logic [c_reg_bus-1:0] out_csr_data,
    output logic [4:0]           out_rd,
    output logic                 out_rd_wen,
    output logic                 out_misalign
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_reg_bus-1:0] r_addr;
    logic [c_reg_bus-1:0] r_wdata;
    logic [2:0]           r_funct3;
    logic                 r_we;
    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_mem_go;
    logic                 w_done;
    logic [c_reg_bus-1:0] w_lane_wdata;
    logic [7:0]           w_lane_wmask;
    logic [c_reg_bus-1:0] w_load_data;

    assign in_ready = (r_state == c_st_idle);
    assign w_accept = in_valid & in_ready;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (in_mem_rd | in_mem_wr) & misaligned(in_funct3, in_addr[2:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_mem_go = w_accept & (in_mem_rd | in_mem_wr) & ~w_misalign;

    // Lane steering works from captured values so the port stays stable while waiting for gnt.
    mem_lsu_align u_align (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr[2:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (dmem_rdata),
        .o_wdata   (w_lane_wdata),
        .o_wmask   (w_lane_wmask),
        .o_rdata   (w_load_data)
    );

    assign dmem_req   = (r_state == c_st_req);
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr[c_reg_bus-1:3], 3'b000};
    assign dmem_wdata = w_lane_wdata;
    assign dmem_wmask = r_we ? w_lane_wmask : 8'h00;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_mem_go) begin
                    w_state_nxt = c_st_req;
                end else if (w_accept) begin
                    w_done = 1'b1;
                end
            end
            c_st_req: begin
                if (dmem_gnt) begin
                    w_state_nxt = r_we ? c_st_idle : c_st_wait;
                    w_done      = r_we;
                end
            end
            c_st_wait: begin
                if (dmem_rvalid) begin
                    w_state_nxt = c_st_idle;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'b000;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mem_go) begin
                r_addr   <= in_addr;
                r_wdata  <= in_wdata;
                r_funct3 <= in_funct3;
                r_we     <= in_mem_wr;
            end
        end
    end

    // Pass-through fields load at accept; only the load result arrives later.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_pc_to_reg  <= 1'b0;
            out_exe_to_reg <= 1'b0;
            out_csr_to_reg <= 1'b0;
            out_mem_data   <= '0;
            out_exe_data   <= '0;
            out_pc_data    <= '0;
            out_csr_data   <= '0;
            out_rd         <= 5'd0;
            out_rd_wen     <= 1'b0;
            out_misalign   <= 1'b0;
        end else begin
            out_valid <= w_done;
            if (w_accept) begin
                out_mem_to_reg <= in_mem_rd & ~w_misalign;
                out_pc_to_reg  <= in_pc_to_reg;
                out_exe_to_reg <= in_exe_to_reg;
                out_csr_to_reg <= in_csr_to_reg;
                out_mem_data   <= '0;
                out_exe_data   <= in_exe_data;
                out_pc_data    <= in_pc_data;
                out_csr_data   <= in_csr_data;
                out_rd         <= in_rd;
                out_rd_wen     <= in_rd_wen & ~in_mem_wr & ~w_misalign;
                out_misalign   <= w_misalign;
            end
            if ((r_state == c_st_wait) && dmem_rvalid) begin
                out_mem_data <= w_load_data;
            end
        end
    end

    a_no_rvalid_on_gnt : assert property (@(posedge clk) disable iff (rst)
        !((r_state == c_st_req) && dmem_gnt && dmem_rvalid));

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed scoreboard bench for mem_stage (define
//               MEM_MISALIGN_TRAP_EN to cover the trap path).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        in_mem_rd = 1'b0, in_mem_wr = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [63:0] in_addr = '0, in_wdata = '0;
    logic        in_pc_to_reg = 1'b0, in_exe_to_reg = 1'b0, in_csr_to_reg = 1'b0;
    logic [63:0] in_exe_data = '0, in_pc_data = '0, in_csr_data = '0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_rd_wen = 1'b0;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        out_valid, out_mem_to_reg, out_pc_to_reg, out_exe_to_reg, out_csr_to_reg;
    logic [63:0] out_mem_data, out_exe_data, out_pc_data, out_csr_data;
    logic [4:0]  out_rd;
    logic        out_rd_wen, out_misalign;

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_pc_to_reg(in_pc_to_reg),
        .in_exe_to_reg(in_exe_to_reg), .in_csr_to_reg(in_csr_to_reg),
        .in_exe_data(in_exe_data), .in_pc_data(in_pc_data), .in_csr_data(in_csr_data),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_mem_to_reg(out_mem_to_reg), .out_pc_to_reg(out_pc_to_reg),
        .out_exe_to_reg(out_exe_to_reg), .out_csr_to_reg(out_csr_to_reg),
        .out_mem_data(out_mem_data), .out_exe_data(out_exe_data), .out_pc_data(out_pc_data),
        .out_csr_data(out_csr_data), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_to_reg;
        logic [2:0]  sel;         // {pc, exe, csr}
        logic [63:0] mem_data, exe_data, pc_data, csr_data;
        logic [4:0]  rd;
        logic        rd_wen, misalign;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic m2r, input logic [2:0] sel, input logic [63:0] md,
                              input logic [63:0] ed, input logic [63:0] pd, input logic [63:0] cd,
                              input logic [4:0] rd, input logic wen, input logic mis);
        exp_t e;
        e.mem_to_reg = m2r; e.sel = sel; e.mem_data = md; e.exe_data = ed;
        e.pc_data = pd; e.csr_data = cd; e.rd = rd; e.rd_wen = wen; e.misalign = mis;
        q.push_back(e);
    endtask

    task automatic issue(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] ed,
                         input logic [63:0] pd, input logic [2:0] sel, input logic [4:0] rd,
                         input logic wen);
        in_valid = 1'b1; in_mem_rd = rd_; in_mem_wr = wr_; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_exe_data = ed; in_pc_data = pd;
        in_csr_data = 64'h0000_0000_0000_0C5A;
        {in_pc_to_reg, in_exe_to_reg, in_csr_to_reg} = sel;
        in_rd = rd; in_rd_wen = wen;
        tick();
        in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
    endtask

    // Load with immediate gnt and one idle WAIT cycle before rvalid.
    task automatic do_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp_data);
        expect_out(1'b1, 3'b000, exp_data, 64'h0, 64'h100, 64'hC5A, 5'd7, 1'b1, 1'b0);
        issue(1'b1, 1'b0, f3, addr, 64'h0, 64'h0, 64'h100, 3'b000, 5'd7, 1'b1);
        chk({name, "_req"}, dmem_req, 1'b1);
        chk({name, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
        chk({name, "_rmask"}, dmem_wmask, 8'h00);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({name, "_req_drop"}, dmem_req, 1'b0);
        chk({name, "_busy"}, in_ready, 1'b0);
        tick();
        chk({name, "_busy_wait"}, in_ready, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 64'h0;
        chk({name, "_ready_back"}, in_ready, 1'b1);
    endtask

    task automatic do_store(input string name, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wd, input logic [7:0] exp_mask,
                            input logic [63:0] exp_wdata, input int gnt_delay);
        expect_out(1'b0, 3'b000, 64'h0, 64'h0, 64'h200, 64'hC5A, 5'd9, 1'b0, 1'b0);
        issue(1'b0, 1'b1, f3, addr, wd, 64'h0, 64'h200, 3'b000, 5'd9, 1'b1);
        for (int i = 0; i <= gnt_delay; i++) begin
            chk({name, "_req"}, dmem_req, 1'b1);
            chk({name, "_we"}, dmem_we, 1'b1);
            chk({name, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
            chk({name, "_wmask"}, dmem_wmask, exp_mask);
            chk({name, "_wdata"}, dmem_wdata, exp_wdata);
            if (i == gnt_delay) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        chk({name, "_req_drop"}, dmem_req, 1'b0);
        chk({name, "_ready_back"}, in_ready, 1'b1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_mem_to_reg", out_mem_to_reg, e.mem_to_reg);
                chk("out_sel", {out_pc_to_reg, out_exe_to_reg, out_csr_to_reg}, e.sel);
                chk("out_mem_data", out_mem_data, e.mem_data);
                chk("out_exe_data", out_exe_data, e.exe_data);
                chk("out_pc_data", out_pc_data, e.pc_data);
                chk("out_csr_data", out_csr_data, e.csr_data);
                chk("out_rd", out_rd, e.rd);
                chk("out_rd_wen", out_rd_wen, e.rd_wen);
                chk("out_misalign", out_misalign, e.misalign);
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rd_wen", out_rd_wen, 1'b0);
        chk("rst_exe_data", out_exe_data, 64'h0);
        chk("rst_misalign", out_misalign, 1'b0);

        // ALU ops back to back: one per cycle, no memory traffic
        expect_out(1'b0, 3'b010, 64'h0, 64'h1234, 64'h80, 64'hC5A, 5'd5, 1'b1, 1'b0);
        expect_out(1'b0, 3'b100, 64'h0, 64'h5678, 64'h84, 64'hC5A, 5'd6, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h1234, 64'h80, 3'b010, 5'd5, 1'b1);
        chk("alu_no_req", dmem_req, 1'b0);
        chk("alu_ready", in_ready, 1'b1);
        issue(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h5678, 64'h84, 3'b100, 5'd6, 1'b1);
        chk("alu2_no_req", dmem_req, 1'b0);
        tick();

        do_load("lb", 3'b000, 64'h1003, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_store("sh", 3'b001, 64'h2002, 64'h0000_0000_0000_ABCD, 8'h0C,
                 64'h0000_0000_ABCD_0000, 3);
        do_load("lwu", 3'b110, 64'h10, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF);
        do_load("lh", 3'b001, 64'h6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load("ld", 3'b011, 64'h28, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
        do_store("sb", 3'b000, 64'h7, 64'h0000_0000_0000_01FF, 8'h80,
                 64'hFF00_0000_0000_0000, 0);
        tick();

        // Reset while a load waits for data: the late rvalid must be dropped
        chk("pre_abort_sb_empty", q.size(), 0);
        issue(1'b1, 1'b0, 3'b011, 64'h20, 64'h0, 64'h0, 64'h300, 3'b000, 5'd8, 1'b1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hCAFE_F00D_1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_req", dmem_req, 1'b0);
        chk("abort_mem_data", out_mem_data, 64'h0);
        tick();
        chk("abort_valid_late", out_valid, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        expect_out(1'b0, 3'b010, 64'h0, 64'h55, 64'h400, 64'hC5A, 5'd3, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 64'h1002, 64'h0, 64'h55, 64'h400, 3'b010, 5'd3, 1'b1);
        chk("mis_no_req", dmem_req, 1'b0);
        chk("mis_ready", in_ready, 1'b1);
        tick();
`endif

        // Stage still usable after the abort
        expect_out(1'b0, 3'b001, 64'h0, 64'h9, 64'h500, 64'hC5A, 5'd31, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h9, 64'h500, 3'b001, 5'd31, 1'b1);
        repeat (3) tick();
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
